seg_bcd_capture: RTL
====================

// Module: seg_bcd_capture
// PURPOSE
// - Reverse path of the BCD-to-seven-segment decoder: watches a multiplexed seven-segment bus (segments + digit anodes) and recovers the BCD value shown on each digit.
// - Used for display loopback self-check and for scraping the display drive in test builds.
// - Sits between the display mux driver outputs and the self-check/status logic.
// PARAMETERS
// - NDIG           4   number of multiplexed digits (2..8)
// - STABLE_CYCLES  4   consecutive identical samples required before capture (2..255)
// PORTS
// - clk          in   1        system clock; all logic rising-edge
// - rst          in   1        synchronous, active-high reset
// - seg          in   7        segment lines, active-high, seg[6:0] = {a,b,c,d,e,f,g}
// - an           in   NDIG     digit anodes, active-low, one-hot-low selects the digit
// - bcd_out      out  4*NDIG   recovered digit k at bcd_out[4k+3:4k]
// - digit_err    out  NDIG     last capture of digit k was not a legal pattern
// - frame_valid  out  1        1-cycle pulse: every digit captured since the previous pulse
// - err_cnt      out  8        invalid-pattern count (present only with CAPTURE_ERR_CNT_EN)
// BEHAVIOUR
// - Clocking: one clock domain. Reset is synchronous and active-high. seg and an are registered once on entry (s_seg, s_an). All other logic uses only the registered values.
// - Reset values:
//   - bcd_out  = all 4'hF
//   - digit_err = 0
//   - frame_valid = 0
//   - seen mask = 0
//   - stab_cnt = 0
//   - err_cnt = 0
//   - FSM = IDLE
// - Decode table (s_seg -> bcd):
//   - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9
//   - 00 (blank) -> 4'hF, err = 0
//   - any other pattern -> 4'hE, err = 1
// - Legal select: s_an has exactly one bit low. All-high or more than one low counts as no select.
// - FSM:
//   - IDLE:  no legal select. stab_cnt = 0. Goes to DWELL when a legal select appears.
//   - DWELL: stab_cnt increments while {s_an,s_seg} equals the previous cycle's value. Any change reloads stab_cnt = 1 and stays in DWELL. A non-legal select goes to IDLE.
//     - When stab_cnt reaches STABLE_CYCLES-1 on a matching cycle: capture, then go to HELD.
//   - HELD: no further capture. Any change of {s_an,s_seg} goes to DWELL with stab_cnt = 1. A non-legal select goes to IDLE.
// - Capture (registered, visible on the next edge): the selected digit gets bcd_out and digit_err, and its seen bit is set.
// - Latency: if pins are constant from edge N, bcd_out is updated after edge N+STABLE_CYCLES+1.
// - frame_valid:
//   - Asserted for 1 cycle on the edge after the seen mask becomes all-ones. The seen mask clears on that same edge.
//   - A capture coinciding with the clear sets its bit in the new mask, so no capture is lost.
// - Re-capturing an already-seen digit before the frame completes overwrites that digit's value. It does not raise frame_valid.
// - Glitches shorter than STABLE_CYCLES samples never update any output.
// - Reset mid-dwell: partial count is discarded and the FSM returns to IDLE. No capture occurs.
// CONFIGURATION
// - CAPTURE_ERR_CNT_EN defined:
//   - err_cnt port exists. It increments by 1 on every capture with err = 1 and saturates at 8'hFF. Blank does not count.
//   - Cleared only by rst.
// - CAPTURE_ERR_CNT_EN undefined: err_cnt port and its counter are absent. Behaviour is otherwise identical.
// TESTING
// - Reset: rst high for 2 cycles -> bcd_out = 16'hFFFF, digit_err = 0, frame_valid = 0, (err_cnt = 0).
// - Scan 4 digits, 8 cycles each, values 3,1,4,9 (seg 79,30,33,7B) -> bcd_out = 16'h9413, exactly one frame_valid pulse, digit_err = 0.
// - Digit 0 shows 5B for 3 cycles then 7F for 8 cycles (STABLE_CYCLES = 4) -> digit 0 = 8; value 5 is never captured.
// - Digit 2 shows 7'h01 -> nibble 2 = 4'hE, digit_err[2] = 1, err_cnt increments 0->1. A second bad capture -> 2.
// - an = 4'b0011 (two digits low) for 20 cycles, then released -> no capture, FSM stays in IDLE, outputs unchanged.
// - rst asserted at stab_cnt = 2, then same pattern held for 10 cycles -> capture after edge STABLE_CYCLES+1 from rst release, not earlier.

Source files
------------

// File: rtl/seg_bcd_capture_if.sv
// seg_bcd_capture_if: seven-segment bus plus recovered-value outputs; err_cnt exists only with CAPTURE_ERR_CNT_EN
interface seg_bcd_capture_if #(parameter int NDIG = 4);
  logic [6:0] seg;
  logic [NDIG-1:0] an;
  logic [4*NDIG-1:0] bcd_out;
  logic [NDIG-1:0] digit_err;
  logic frame_valid;
`ifdef CAPTURE_ERR_CNT_EN
  logic [7:0] err_cnt;
  modport master(output seg, an, input bcd_out, digit_err, frame_valid, err_cnt);
  modport slave(input seg, an, output bcd_out, digit_err, frame_valid, err_cnt);
`else
  modport master(output seg, an, input bcd_out, digit_err, frame_valid);
  modport slave(input seg, an, output bcd_out, digit_err, frame_valid);
`endif
endinterface

// File: rtl/seg_bcd_capture.sv
// seg_bcd_capture: recovers BCD digits from a multiplexed seven-segment bus; CAPTURE_ERR_CNT_EN adds err_cnt
module seg_bcd_capture #(
  parameter int NDIG = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  seg_bcd_capture_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DWELL, HELD} state_t;
  state_t state, state_n;
  logic [6:0] s_seg, p_seg;
  logic [NDIG-1:0] s_an, p_an, cap_sel, seen, err_q;
  logic [4*NDIG-1:0] bcd_q;
  logic [7:0] cnt, cnt_n;
  logic [3:0] dec_bcd, cap_bcd;
  logic dec_err, cap_err, cap, cap_en, fv, legal, same;
  assign legal = $onehot(~s_an);
  assign same = {s_an, s_seg} == {p_an, p_seg};
  // register the pins once, and keep the previous sample for the stability compare
  always_ff @(posedge clk)
    if (rst) begin
      s_seg <= '0;
      p_seg <= '0;
      s_an <= '1;
      p_an <= '1;
    end else begin
      s_seg <= bus.seg;
      s_an <= bus.an;
      p_seg <= s_seg;
      p_an <= s_an;
    end
  // segment pattern to BCD; blank reads as F, anything unknown as E with err
  always_comb begin
    dec_err = 1'b0;
    case (s_seg)
      7'h7E: dec_bcd = 4'd0;
      7'h30: dec_bcd = 4'd1;
      7'h6D: dec_bcd = 4'd2;
      7'h79: dec_bcd = 4'd3;
      7'h33: dec_bcd = 4'd4;
      7'h5B: dec_bcd = 4'd5;
      7'h5F: dec_bcd = 4'd6;
      7'h70: dec_bcd = 4'd7;
      7'h7F: dec_bcd = 4'd8;
      7'h7B: dec_bcd = 4'd9;
      7'h00: dec_bcd = 4'hF;
      default: begin
        dec_bcd = 4'hE;
        dec_err = 1'b1;
      end
    endcase
  end
  // state and dwell counter
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
    cnt <= rst ? 8'd0 : cnt_n;
  end
  // a change restarts the dwell at one sample; the last matching sample triggers the capture
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cap = 1'b0;
    if (!legal) begin
      state_n = IDLE;
      cnt_n = 8'd0;
    end else if (state == IDLE || !same) begin
      state_n = DWELL;
      cnt_n = 8'd1;
    end else if (state == DWELL) begin
      cap = cnt == 8'(STABLE_CYCLES - 1);
      state_n = cap ? HELD : DWELL;
      cnt_n = cap ? cnt : cnt + 8'd1;
    end
  end
  // capture stage: latch decision, selected digit and decoded value
  always_ff @(posedge clk)
    if (rst) begin
      cap_en <= 1'b0;
      cap_sel <= '0;
      cap_bcd <= '0;
      cap_err <= 1'b0;
    end else begin
      cap_en <= cap;
      cap_sel <= ~s_an;
      cap_bcd <= dec_bcd;
      cap_err <= dec_err;
    end
  // apply capture; a full seen mask pulses frame_valid and restarts with any coinciding capture
  always_ff @(posedge clk)
    if (rst) begin
      bcd_q <= '1;
      err_q <= '0;
      seen <= '0;
      fv <= 1'b0;
    end else begin
      fv <= &seen;
      seen <= (&seen ? '0 : seen) | (cap_en ? cap_sel : '0);
      for (int k = 0; k < NDIG; k++)
        if (cap_en && cap_sel[k]) begin
          bcd_q[4*k +: 4] <= cap_bcd;
          err_q[k] <= cap_err;
        end
    end
  assign bus.bcd_out = bcd_q;
  assign bus.digit_err = err_q;
  assign bus.frame_valid = fv;
`ifdef CAPTURE_ERR_CNT_EN
  logic [7:0] ec;
  // saturating count of captures that decoded as illegal
  always_ff @(posedge clk)
    if (rst) ec <= 8'd0;
    else if (cap_en && cap_err && ec != 8'hFF) ec <= ec + 8'd1;
  assign bus.err_cnt = ec;
`endif
endmodule
